// File: rtl/risc_fetch.sv
// Instruction fetch stage: drives a single-outstanding-request instruction memory
// port and loads the IF/ID pipeline register, handling stalls, flushes and redirects.
module risc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        pc_src_e,
  input  logic [31:0] pc_target_e,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,  // request outstanding, response will be used
    S_DRAIN = 2'd1,  // request outstanding, response will be discarded
    S_HOLD  = 2'd2   // response captured in hold_buf, waiting for decode
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [31:0] pc_f;
  logic [31:0] req_addr;
  logic [31:0] redirect_pc;
  logic [31:0] hold_buf;

  logic [31:0] pc_nxt;
  logic [31:0] redirect_nxt;
  logic [31:0] hold_nxt;

  logic        accept;
  logic [31:0] target_pc;
  logic [31:0] seq_pc;
  logic        deliver;
  logic [31:0] deliver_instr;

  // A flush is treated like a stall so a fetched word is never lost to a bubble
  // unless a redirect makes it stale anyway.
  assign accept    = !stall_f && !stall_d && !flush_d;
  assign target_pc = pc_target_e & ~32'h0000_0003;
  assign seq_pc    = pc_f + 32'd4;

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_REQ;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a redirect wins over any stall.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_REQ: begin
        if (imem_ack) begin
          if (!pc_src_e && !accept) state_nxt = S_HOLD;
        end else if (pc_src_e) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (imem_ack) state_nxt = S_REQ;
      end
      S_HOLD: begin
        if (pc_src_e || accept) state_nxt = S_REQ;
      end
      default: state_nxt = S_REQ;
    endcase
  end

  // Output and datapath control for the current state.
  // NOTE: every signal assigned in this block gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    imem_req      = !rst && (state != S_HOLD);
    imem_addr     = req_addr;
    pc_nxt        = req_addr;
    redirect_nxt  = redirect_pc;
    hold_nxt      = hold_buf;
    deliver       = 1'b0;
    deliver_instr = imem_rdata;
    unique case (state)
      S_REQ: begin
        if (imem_ack) begin
          if (pc_src_e) begin
            pc_nxt = target_pc;
          end else if (accept) begin
            deliver = 1'b1;
            pc_nxt  = seq_pc;
          end else begin
            hold_nxt = imem_rdata;
          end
        end else if (pc_src_e) begin
          // req_addr must stay put until the in-flight response arrives.
          redirect_nxt = target_pc;
        end
      end
      S_DRAIN: begin
        if (imem_ack) begin
          pc_nxt = pc_src_e ? target_pc : redirect_pc;
        end else if (pc_src_e) begin
          redirect_nxt = target_pc;
        end
      end
      S_HOLD: begin
        deliver_instr = hold_buf;
        if (pc_src_e) begin
          pc_nxt = target_pc;
        end else if (accept) begin
          deliver = 1'b1;
          pc_nxt  = seq_pc;
        end
      end
      default: begin
        pc_nxt = req_addr;
      end
    endcase
  end

  // Fetch-side registers. pc_f and req_addr always move together; pc_f feeds
  // the sequential adder, req_addr drives the memory port.
  // NOTE: hold_buf is a single data register, not an array, so it is reset along
  // with the rest of the state to keep post-reset contents deterministic.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_f        <= RESET_PC;
      req_addr    <= RESET_PC;
      redirect_pc <= 32'h0000_0000;
      hold_buf    <= 32'h0000_0000;
    end else begin
      pc_f        <= pc_nxt;
      req_addr    <= pc_nxt;
      redirect_pc <= redirect_nxt;
      hold_buf    <= hold_nxt;
    end
  end

  // IF/ID register: flush > stall > delivery > bubble.
  always_ff @(posedge clk) begin
    if (rst || flush_d) begin
      instr_d    <= NOP_INST;
      pc_d       <= 32'h0000_0000;
      pc_plus4_d <= 32'h0000_0000;
      valid_d    <= 1'b0;
    end else if (!stall_d) begin
      if (deliver) begin
        instr_d    <= deliver_instr;
        pc_d       <= req_addr;
        pc_plus4_d <= seq_pc;
        valid_d    <= 1'b1;
      end else begin
        instr_d    <= NOP_INST;
        pc_d       <= 32'h0000_0000;
        pc_plus4_d <= 32'h0000_0000;
        valid_d    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_risc_fetch.sv
// Self-checking bench for risc_fetch: directed scenarios followed by random
// stall/flush/redirect/ack traffic compared against a transaction-level model.
module tb_risc_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_f;
  logic        stall_d;
  logic        flush_d;
  logic        pc_src_e;
  logic [31:0] pc_target_e;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] scramble = 32'h0;

  // Reference model: where the fetch unit is going, whether the in-flight
  // response is stale, whether a word is parked, and the expected IF/ID view.
  logic [31:0] m_addr;
  logic        m_stale;
  logic [31:0] m_stale_tgt;
  logic        m_parked;
  logic [31:0] m_parked_word;
  logic [31:0] e_instr;
  logic [31:0] e_pc;
  logic [31:0] e_pc4;
  logic        e_valid;

  risc_fetch #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall_f    (stall_f),
    .stall_d    (stall_d),
    .flush_d    (flush_d),
    .pc_src_e   (pc_src_e),
    .pc_target_e(pc_target_e),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr_d    (instr_d),
    .pc_d       (pc_d),
    .pc_plus4_d (pc_plus4_d),
    .valid_d    (valid_d)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_addr        = RESET_PC;
    m_stale       = 1'b0;
    m_stale_tgt   = 32'h0;
    m_parked      = 1'b0;
    m_parked_word = 32'h0;
    e_instr       = NOP_INST;
    e_pc          = 32'h0;
    e_pc4         = 32'h0;
    e_valid       = 1'b0;
  endtask

  // One clock cycle: drive inputs just after a falling edge, check the memory
  // port, advance the model, check IF/ID after the rising edge.
  task automatic step(input logic r, input logic sf, input logic sd, input logic fl,
                      input logic ps, input logic [31:0] tgt, input logic ack);
    logic [31:0] tgt_a;
    logic        take;
    logic        got_word;
    logic [31:0] word;
    logic [31:0] word_pc;
    rst         = r;
    stall_f     = sf;
    stall_d     = sd;
    flush_d     = fl;
    pc_src_e    = ps;
    pc_target_e = tgt;
    imem_ack    = ack;
    imem_rdata  = ack ? (imem_addr ^ scramble) : 32'hDEAD_BEEF;
    #1;
    check("imem_req", {31'b0, imem_req}, {31'b0, !r && !m_parked});
    check("imem_addr", imem_addr, m_addr);

    tgt_a    = {tgt[31:2], 2'b00};
    take     = !sf && !sd && !fl;
    got_word = 1'b0;
    word     = 32'h0;
    word_pc  = m_addr;
    if (r) begin
      model_reset();
    end else begin
      if (m_parked) begin
        if (ps) begin
          m_parked = 1'b0;
          m_addr   = tgt_a;
        end else if (take) begin
          got_word = 1'b1;
          word     = m_parked_word;
          m_parked = 1'b0;
          m_addr   = m_addr + 32'd4;
        end
      end else if (m_stale) begin
        if (ack) begin
          m_addr  = ps ? tgt_a : m_stale_tgt;
          m_stale = 1'b0;
        end else if (ps) begin
          m_stale_tgt = tgt_a;
        end
      end else if (ack) begin
        if (ps) begin
          m_addr = tgt_a;
        end else if (take) begin
          got_word = 1'b1;
          word     = imem_rdata;
          m_addr   = m_addr + 32'd4;
        end else begin
          m_parked      = 1'b1;
          m_parked_word = imem_rdata;
        end
      end else if (ps) begin
        m_stale     = 1'b1;
        m_stale_tgt = tgt_a;
      end

      if (fl || (!sd && !got_word)) begin
        e_instr = NOP_INST;
        e_pc    = 32'h0;
        e_pc4   = 32'h0;
        e_valid = 1'b0;
      end else if (!sd) begin
        e_instr = word;
        e_pc    = word_pc;
        e_pc4   = word_pc + 32'd4;
        e_valid = 1'b1;
      end
    end

    @(posedge clk);
    #1;
    check("instr_d", instr_d, e_instr);
    check("pc_d", pc_d, e_pc);
    check("pc_plus4_d", pc_plus4_d, e_pc4);
    check("valid_d", {31'b0, valid_d}, {31'b0, e_valid});
    @(negedge clk);
  endtask

  initial begin
    rst         = 1'b1;
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    flush_d     = 1'b0;
    pc_src_e    = 1'b0;
    pc_target_e = 32'h0;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);

    check("rst_instr", instr_d, NOP_INST);
    check("rst_valid", {31'b0, valid_d}, 32'h0);
    check("rst_addr", imem_addr, RESET_PC);

    // Zero-wait streaming, then a decode stall while a word returns at 8.
    step(0, 0, 0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 0, 0, 32'h0, 1);
    check("stream_pc", pc_d, 32'h4);
    check("stream_valid", {31'b0, valid_d}, 32'h1);
    step(0, 0, 1, 0, 0, 32'h0, 1);
    step(0, 0, 1, 0, 0, 32'h0, 0);
    step(0, 0, 1, 0, 0, 32'h0, 0);
    check("hold_req", {31'b0, imem_req}, 32'h0);
    check("hold_frozen_pc", pc_d, 32'h4);
    step(0, 0, 0, 0, 0, 32'h0, 0);
    check("hold_release_instr", instr_d, 32'h8);
    check("hold_release_pc", pc_d, 32'h8);
    check("hold_next_addr", imem_addr, 32'hC);
    step(0, 0, 0, 0, 0, 32'h0, 1);
    check("stream_pc_c", pc_d, 32'hC);

    // Redirect while the request to 0x10 is outstanding; ack two cycles later.
    step(0, 0, 0, 0, 1, 32'h40, 0);
    step(0, 0, 0, 0, 0, 32'h0, 0);
    step(0, 0, 0, 0, 0, 32'h0, 1);
    check("drain_valid", {31'b0, valid_d}, 32'h0);
    check("drain_next_addr", imem_addr, 32'h40);

    // Flush together with stall_d.
    step(0, 0, 1, 1, 0, 32'h0, 1);
    check("flush_instr", instr_d, 32'h0000_0013);
    check("flush_valid", {31'b0, valid_d}, 32'h0);
    step(0, 0, 0, 0, 0, 32'h0, 0);
    check("after_flush_pc", pc_d, 32'h40);

    // Wraparound at the top of the address space (low target bits ignored).
    step(0, 0, 0, 0, 1, 32'hFFFF_FFFF, 0);
    step(0, 0, 0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 0, 0, 32'h0, 1);
    check("wrap_pc", pc_d, 32'hFFFF_FFFC);
    check("wrap_pc4", pc_plus4_d, 32'h0);
    check("wrap_next_addr", imem_addr, 32'h0);

    // Reset while a word is parked, with a late ack during reset.
    step(0, 1, 0, 0, 0, 32'h0, 1);
    step(1, 0, 0, 0, 0, 32'h0, 1);
    check("rst_hold_addr", imem_addr, RESET_PC);
    check("rst_hold_valid", {31'b0, valid_d}, 32'h0);
    step(0, 0, 0, 0, 0, 32'h0, 1);
    check("rst_hold_first_pc", pc_d, RESET_PC);

    // Random traffic.
    scramble = $urandom;
    for (int i = 0; i < 600; i++) begin
      logic r, sf, sd, fl, ps, ack;
      r   = ($urandom_range(0, 59) == 0);
      sf  = ($urandom_range(0, 4) == 0);
      sd  = ($urandom_range(0, 4) == 0);
      fl  = ($urandom_range(0, 9) == 0);
      ps  = ($urandom_range(0, 9) == 0);
      ack = !m_parked && ($urandom_range(0, 9) < 6);
      step(r, sf, sd, fl, ps, $urandom, ack);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
